// File: rtl/dnn_pkg.sv
// Shared definitions for the MNIST engine result-side logic.
package dnn_pkg;

  localparam int DATA_WIDTH  = 9;
  localparam int NUM_CLASSES = 10;
  // Image/weight store address width of the engine; carried here so the
  // engine and this block agree on one set of constants.
  localparam int ADDR_WIDTH  = 13;

  // Digit reported when a run is aborted because done never arrived.
  localparam logic [3:0] TIMEOUT_DIGIT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_WAIT   = 3'd3,
    ST_SCAN   = 3'd4,
    ST_RESULT = 3'd5
  } reader_state_t;

endpackage

// File: rtl/dnn_result_reader_argmax.sv
// Running argmax over a stream of signed scores. best_idx/best_score already
// include the score presented this cycle, so the caller can capture the final
// winner on the same edge that consumes the last class.
module dnn_argmax_acc #(
  parameter int DATA_WIDTH = dnn_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [3:0]            idx,
  input  logic [DATA_WIDTH-1:0] score,
  output logic [3:0]            best_idx,
  output logic [DATA_WIDTH-1:0] best_score
);

  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [3:0]            idx_q;
  logic [DATA_WIDTH-1:0] score_q;
  logic                  take;

  // Strictly greater replaces the best, so ties keep the earlier (lower) index.
  always_comb begin
    take       = enable && ($signed(score) > $signed(score_q));
    best_idx   = take ? idx   : idx_q;
    best_score = take ? score : score_q;
  end

  // Hold the running best; clear restarts the sweep from the most-negative score.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      score_q <= MOST_NEG;
    end else if (clear) begin
      idx_q   <= '0;
      score_q <= MOST_NEG;
    end else if (enable) begin
      idx_q   <= best_idx;
      score_q <= best_score;
    end
  end

endmodule

// File: rtl/dnn_result_reader.sv
// Run controller for the inference engine: soft-reset, start, wait for done
// (with timeout), sweep all class scores and return the argmax.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. req_ready is high only in IDLE. res_valid, once high, stays high
// with stable res_* until res_ready is seen; the result registers keep their
// value afterwards and only res_valid qualifies them.
module dnn_result_reader #(
  parameter int DATA_WIDTH     = dnn_pkg::DATA_WIDTH,
  parameter int NUM_CLASSES    = dnn_pkg::NUM_CLASSES,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  output logic                  eng_reset,
  output logic                  eng_start,
  input  logic                  eng_done,
  output logic [3:0]            eng_idx,
  input  logic [DATA_WIDTH-1:0] eng_out,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [3:0]            res_digit,
  output logic [DATA_WIDTH-1:0] res_score,
  output logic                  res_timeout,
  output logic [2:0]            dbg_state
);

  import dnn_pkg::*;

  localparam int              CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      LAST_IDX = 4'(NUM_CLASSES - 1);

  reader_state_t         state_q, state_d;
  logic [CNT_W-1:0]      wait_cnt_q;
  logic                  eng_reset_d, eng_start_d, res_valid_d;
  logic [3:0]            eng_idx_d;
  logic                  load_scan, load_timeout;
  logic                  acc_clear, acc_enable;
  logic [3:0]            best_idx;
  logic [DATA_WIDTH-1:0] best_score;

  assign req_ready = (state_q == ST_IDLE);
  assign dbg_state = state_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; in WAIT a done in the final counted cycle still wins.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (req_valid) state_d = ST_CLEAR;
      ST_CLEAR:  state_d = ST_LAUNCH;
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (eng_done)                     state_d = ST_SCAN;
        else if (wait_cnt_q == CNT_LAST)  state_d = ST_RESULT;
      end
      ST_SCAN:   if (eng_idx == LAST_IDX) state_d = ST_RESULT;
      ST_RESULT: if (res_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output leaves a flop.
  always_comb begin
    eng_reset_d  = (state_d == ST_CLEAR);
    eng_start_d  = (state_d == ST_LAUNCH);
    res_valid_d  = (state_d == ST_RESULT);
    eng_idx_d    = (state_q == ST_SCAN && state_d == ST_SCAN) ? eng_idx + 4'd1 : 4'd0;
    load_scan    = (state_q == ST_SCAN) && (state_d == ST_RESULT);
    load_timeout = (state_q == ST_WAIT) && (state_d == ST_RESULT);
    acc_clear    = (state_q == ST_WAIT) && eng_done;
    acc_enable   = (state_q == ST_SCAN);
  end

  // Registered control outputs and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_reset   <= 1'b0;
      eng_start   <= 1'b0;
      eng_idx     <= '0;
      res_valid   <= 1'b0;
      res_digit   <= '0;
      res_score   <= '0;
      res_timeout <= 1'b0;
    end else begin
      eng_reset <= eng_reset_d;
      eng_start <= eng_start_d;
      eng_idx   <= eng_idx_d;
      res_valid <= res_valid_d;
      if (load_scan) begin
        res_digit   <= best_idx;
        res_score   <= best_score;
        res_timeout <= 1'b0;
      end else if (load_timeout) begin
        res_digit   <= TIMEOUT_DIGIT;
        res_score   <= '0;
        res_timeout <= 1'b1;
      end
    end
  end

  // WAIT-cycle counter, restarted by every launch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       wait_cnt_q <= '0;
    else if (state_q == ST_LAUNCH) wait_cnt_q <= '0;
    else if (state_q == ST_WAIT)   wait_cnt_q <= wait_cnt_q + 1'b1;
  end

  dnn_argmax_acc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_argmax (
    .clk        (clk),
    .rst        (rst),
    .clear      (acc_clear),
    .enable     (acc_enable),
    .idx        (eng_idx),
    .score      (eng_out),
    .best_idx   (best_idx),
    .best_score (best_score)
  );

endmodule

// File: tb/tb_dnn_result_reader.sv
// Bench for dnn_result_reader: engine stub driven by tasks, argmax reference
// model over plain integers, expected-result queue and a final report.
module tb_dnn_result_reader;

  localparam int DW = 9;
  localparam int NC = 10;
  localparam int TO = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req_valid, req_ready, eng_reset, eng_start, eng_done;
  logic [3:0]    eng_idx;
  logic [DW-1:0] eng_out;
  logic          res_valid, res_ready, res_timeout;
  logic [3:0]    res_digit;
  logic [DW-1:0] res_score;
  logic [2:0]    dbg_state;

  logic signed [DW-1:0] scores [NC];
  assign eng_out = (eng_idx < 4'(NC)) ? scores[eng_idx] : '0;

  dnn_result_reader #(
    .DATA_WIDTH     (DW),
    .NUM_CLASSES    (NC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .eng_reset   (eng_reset),
    .eng_start   (eng_start),
    .eng_done    (eng_done),
    .eng_idx     (eng_idx),
    .eng_out     (eng_out),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_digit   (res_digit),
    .res_score   (res_score),
    .res_timeout (res_timeout),
    .dbg_state   (dbg_state)
  );

  // Pulse counters for engine controls.
  int n_reset = 0;
  int n_start = 0;
  always @(posedge clk) begin
    if (eng_reset) n_reset <= n_reset + 1;
    if (eng_start) n_start <= n_start + 1;
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [13:0] exp_q[$];  // {digit, score, timeout}

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: argmax over integers, first maximum wins.
  function automatic logic [13:0] model_result(input bit timed_out);
    int best_i;
    int best_v;
    if (timed_out) return {4'hF, 9'd0, 1'b1};
    best_i = 0;
    best_v = int'(scores[0]);
    for (int i = 1; i < NC; i++) begin
      if (int'(scores[i]) > best_v) begin
        best_v = int'(scores[i]);
        best_i = i;
      end
    end
    return {4'(best_i), 9'(best_v), 1'b0};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_scores(input int v[NC]);
    for (int i = 0; i < NC; i++) scores[i] = DW'(v[i]);
  endtask

  task automatic random_scores();
    for (int i = 0; i < NC; i++) scores[i] = DW'($urandom_range(0, 511));
  endtask

  // One full request. done_delay < 0: engine never finishes.
  // stuck: eng_done already high before the request. hold: cycles with
  // res_ready low in RESULT. ready_early: res_ready high before res_valid.
  task automatic run_req(input int done_delay, input bit stuck, input int hold, input bit ready_early);
    logic [13:0] exp;
    int  k;
    int  r0, s0;
    bit  ok;
    logic [3:0]    d0;
    logic [DW-1:0] sc0;
    logic          t0;
    exp_q.push_back(model_result(done_delay < 0));
    r0 = n_reset;
    s0 = n_start;
    check("idle_req_ready", req_ready, 1);
    eng_done  = stuck;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("clear_eng_reset", eng_reset, 1);
    check("clear_eng_start", eng_start, 0);
    check("clear_req_ready", req_ready, 0);
    tick();
    check("launch_eng_start", eng_start, 1);
    check("launch_eng_reset", eng_reset, 0);
    tick();  // first WAIT cycle
    ok = 1'b1;
    if (done_delay >= 0) begin
      for (int i = 0; i < done_delay; i++) begin
        if (eng_idx != 4'd0 || res_valid) ok = 1'b0;
        tick();
      end
      eng_done = 1'b1;
    end
    if (ready_early) res_ready = 1'b1;
    k = 0;
    while (!res_valid && k < 200) begin
      if (done_delay < 0 && eng_idx != 4'd0) ok = 1'b0;
      tick();
      k++;
      if (done_delay >= 0 && k <= NC && eng_idx != 4'(k - 1)) ok = 1'b0;
    end
    check("result_latency", k, (done_delay < 0) ? TO : NC + 1);
    check("eng_idx_sequence", ok, 1);
    exp = exp_q.pop_front();
    check("res_digit", res_digit, exp[13:10]);
    check("res_score", res_score, exp[9:1]);
    check("res_timeout", res_timeout, exp[0]);
    check("result_req_ready", req_ready, 0);
    if (!ready_early) begin
      ok  = 1'b1;
      d0  = res_digit;
      sc0 = res_score;
      t0  = res_timeout;
      for (int h = 0; h < hold; h++) begin
        req_valid = 1'($urandom_range(0, 1));
        tick();
        if (!res_valid || req_ready || eng_reset || res_digit != d0 || res_score != sc0 || res_timeout != t0)
          ok = 1'b0;
      end
      req_valid = 1'b0;
      check("result_hold_stable", ok, 1);
      res_ready = 1'b1;
    end
    tick();
    res_ready = 1'b0;
    eng_done  = 1'b0;
    check("accept_res_valid", res_valid, 0);
    check("accept_req_ready", req_ready, 1);
    tick();
    check("reset_pulses", n_reset - r0, 1);
    check("start_pulses", n_start - s0, 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_eng_reset"}, eng_reset, 0);
    check({tag, "_eng_start"}, eng_start, 0);
    check({tag, "_eng_idx"}, eng_idx, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_digit"}, res_digit, 0);
    check({tag, "_res_score"}, res_score, 0);
    check({tag, "_res_timeout"}, res_timeout, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int v_a   [NC] = '{-10, 3, 120, 7, -256, 0, 5, 119, 1, 2};
    int v_min [NC] = '{-256, -256, -256, -256, -256, -256, -256, -256, -256, -256};
    int v_tie [NC] = '{-3, 12, 49, 50, -100, 0, 7, 49, 50, -256};
    int k;
    rst = 1'b1;
    req_valid = 1'b0;
    res_ready = 1'b0;
    eng_done  = 1'b0;
    for (int i = 0; i < NC; i++) scores[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("por");
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Directed: reference scores, done 40 cycles after start, long hold.
    load_scores(v_a);
    run_req(39, 1'b0, 20, 1'b0);

    // Reset in the middle of SCAN.
    random_scores();
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    eng_done = 1'b1;
    k = 0;
    while (eng_idx != 4'd5 && k < 50) begin
      tick();
      k++;
    end
    check("reach_scan_idx5", eng_idx, 5);
    #2 rst = 1'b1;
    #1;
    check_reset_values("midscan");
    eng_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    random_scores();
    run_req(5, 1'b0, 2, 1'b0);

    // All at the most-negative value, one-cycle handshake.
    load_scores(v_min);
    run_req(0, 1'b0, 0, 1'b1);

    // Tie at classes 3 and 8.
    load_scores(v_tie);
    run_req(3, 1'b0, 1, 1'b0);

    // Timeout with no done.
    random_scores();
    run_req(-1, 1'b0, 3, 1'b0);

    // Done stuck high from before the request.
    random_scores();
    run_req(0, 1'b1, 2, 1'b0);

    // Randomized runs.
    for (int r = 0; r < 10; r++) begin
      random_scores();
      run_req(int'($urandom_range(0, 30)), 1'b0, int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
    end

    check("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dnn_result_reader.md
# dnn_result_reader

Run controller and result reader for the MNIST inference engine; sits on the engine's output side (`out_idx`/`out`) and its `start`/`reset`/`done` controls. Accepts one classification request, soft-resets and launches the engine, waits for completion with a timeout, then sweeps all 10 class scores and returns the argmax digit and its score through a valid/ready result port. Memory traffic (`mem_addr`/`mem_data`) stays between the engine and the image/weight store; this block never touches it.

## Interface
- `DATA_WIDTH`, 9: signed fixed-point score width; must match the engine.
- `NUM_CLASSES`, 10: number of output neurons scanned.
- `TIMEOUT_CYCLES`, 1048576: maximum cycles spent in WAIT before aborting.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request a classification run.
- `req_ready`  out  1  high only in IDLE.
- `eng_reset`  out  1  one-cycle soft-reset pulse to the engine.
- `eng_start`  out  1  one-cycle start pulse to the engine.
- `eng_done`  in  1  engine completion level.
- `eng_idx`  out  4  class index to the engine's output select (`out_idx`).
- `eng_out`  in  DATA_WIDTH  signed score for `eng_idx`; combinational from `eng_idx`.
- `res_valid`  out  1  result available; held until accepted.
- `res_ready`  in  1  consumer accepts result.
- `res_digit`  out  4  argmax class, 0..9; 4'hF on timeout.
- `res_score`  out  DATA_WIDTH  signed maximum score; 0 on timeout.
- `res_timeout`  out  1  run aborted by timeout.

## Operation
- States: IDLE, CLEAR, LAUNCH, WAIT, SCAN, RESULT.
- IDLE: `req_ready`=1. `req_valid`&&`req_ready` -> CLEAR.
- CLEAR: `eng_reset`=1 for exactly this cycle -> LAUNCH.
- LAUNCH: `eng_start`=1 for exactly this cycle; timeout counter cleared -> WAIT.
- WAIT: `eng_done` sampled every cycle. `eng_done`=1 -> SCAN, with `eng_idx`=0, best_idx=0, best_score=most-negative value. Counter reaches TIMEOUT_CYCLES-1 without done -> RESULT with `res_timeout`=1, `res_digit`=4'hF, `res_score`=0. Done and timeout in the same cycle: done wins.
- SCAN: one class per cycle. In cycle with `eng_idx`=i, `eng_out` is compared signed against best_score; strictly greater replaces best (ties keep the lower index). `eng_idx` increments; after i=NUM_CLASSES-1 -> RESULT with registered best values and `res_timeout`=0.
- RESULT: `res_valid`=1, outputs stable. `res_valid`&&`res_ready` -> IDLE in the next cycle. `req_valid` is ignored outside IDLE.
- Result registers keep their last value after acceptance; `res_valid` alone qualifies them.
- Score arithmetic: pure signed DATA_WIDTH comparison, no widening or saturation.

## Timing
- Reset values: state IDLE, `req_ready`=1, `eng_reset`=0, `eng_start`=0, `eng_idx`=0, `res_valid`=0, `res_digit`=0, `res_score`=0, `res_timeout`=0.
- All outputs registered; `req_ready` decoded from the state register only.
- Accept edge to `eng_reset` high: 1 cycle; to `eng_start` high: 2 cycles.
- `eng_done` is never sampled before the first WAIT cycle (the cycle after `eng_start`).
- Done seen in WAIT cycle t: SCAN covers t+1..t+10, and `res_valid` rises at t+11.
- `res_ready` already high when `res_valid` rises: one-cycle handshake; `req_ready` returns on the next cycle.
- Asynchronous `rst` mid-run: immediate return to reset values; the engine's state is left as-is, and the next request's CLEAR pulse reinitialises it.
- `eng_idx` is 0 outside SCAN.

## Structure
- Shared package `dnn_pkg`: `DATA_WIDTH`, `NUM_CLASSES`, `ADDR_WIDTH`, the state enum `reader_state_t`, and the timeout digit constant 4'hF.
- One sub-module, `dnn_argmax_acc`. It has clear, enable, idx and score inputs, and best_idx and best_score outputs, and holds the strict-greater, lowest-index-wins comparator.
- The FSM, timeout counter and result registers live in `dnn_result_reader`.

## Test plan
- Scores {−10,3,120,7,−256,0,5,119,1,2}, done 40 cycles after start -> `res_digit`=2, `res_score`=120, `res_timeout`=0. `res_valid` rises exactly 11 cycles after done is seen.
- All ten scores −256 -> `res_digit`=0, `res_score`=−256. Scores with 50 at classes 3 and 8 (others lower) -> `res_digit`=3 (tie keeps the lower index).
- Done never asserted, TIMEOUT_CYCLES=64 -> RESULT 64 cycles into WAIT with `res_timeout`=1, `res_digit`=4'hF, `res_score`=0, and no SCAN activity on `eng_idx`.
- Hold `res_ready`=0 for 20 cycles -> outputs stable and `req_ready`=0 throughout. Pulsing `req_valid` during RESULT starts no run. After acceptance, a second request yields a fresh CLEAR/LAUNCH pair.
- Assert `rst` during SCAN at `eng_idx`=5 -> all outputs at reset values immediately. A new request completes normally with the correct argmax.
- `eng_done` stuck high from the previous run -> no sampling until WAIT; CLEAR and LAUNCH each pulse exactly once per request.
